// File: rtl/shift_seq_ctrl_pkg.sv
// shift_seq_ctrl_pkg: FSM state encoding and shift-type codes shared by the shift sequencer files
package shift_seq_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  localparam logic SH_LOGIC = 1'b0;
  localparam logic SH_ARITH = 1'b1;
endpackage

// File: rtl/shift_seq_ctrl_if.sv
// shift_seq_ctrl_if: request/result handshake bundle for the shift sequencer
//   request : in_valid, in_ready, in_data[W], in_amt[SW], in_type
//   result  : out_valid, out_ready, out_data[W], out_sticky; status busy
//   master = requester/consumer side, slave = sequencer side
interface shift_seq_ctrl_if #(parameter int W = 4, parameter int SW = 3);
  logic in_valid, in_ready, in_type;
  logic [W-1:0] in_data;
  logic [SW-1:0] in_amt;
  logic out_valid, out_ready, busy, out_sticky;
  logic [W-1:0] out_data;
  modport master (output in_valid, in_data, in_amt, in_type, out_ready,
                  input in_ready, out_valid, out_data, busy, out_sticky);
  modport slave (input in_valid, in_data, in_amt, in_type, out_ready,
                 output in_ready, out_valid, out_data, busy, out_sticky);
endinterface

// File: rtl/shift_seq_ctrl_datapath.sv
// shr_datapath: W-bit right-shift register with load and single-bit logical/arithmetic shift
//   clk, rst_b (async active-low, resets to RST_VAL), ld loads d (priority over sh),
//   sh shifts right once using sh_type, q is the register contents
module shr_datapath import shift_seq_ctrl_pkg::*; #(
  parameter int W = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         ld,
  input  logic         sh,
  input  logic         sh_type,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) q <= RST_VAL;
    else if (ld) q <= d;
    else if (sh) q <= {sh_type == SH_ARITH ? q[W-1] : 1'b0, q[W-1:1]};
endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequences ld/sh controls of shr_datapath to apply in_amt right shifts per request
//   clk, rst_b (async active-low), s: slave side of shift_seq_ctrl_if
//   in_ready only in IDLE, out_valid only in DONE, busy in SHIFT or DONE
//   SHIFT_STICKY_EN: when defined, out_sticky is the OR of all bits shifted out;
//   otherwise out_sticky is tied low
module shift_seq_ctrl import shift_seq_ctrl_pkg::*; #(
  parameter int W = 4,
  parameter int SW = 3,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic clk,
  input  logic rst_b,
  shift_seq_ctrl_if.slave s
);
  state_t state;
  logic [SW-1:0] cnt;
  logic typ, acc, sh;
  assign acc = s.in_valid && s.in_ready;
  assign sh = state == SHIFT;
  shr_datapath #(.W(W), .RST_VAL(RST_VAL)) u_dp (
    .clk(clk), .rst_b(rst_b), .ld(acc), .sh(sh), .sh_type(typ), .d(s.in_data), .q(s.out_data)
  );
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      state <= IDLE;
      cnt <= '0;
      typ <= SH_LOGIC;
      s.in_ready <= 1'b1;
      s.out_valid <= 1'b0;
      s.busy <= 1'b0;
    end else
      case (state)
        IDLE: if (acc) begin
          state <= s.in_amt == '0 ? DONE : SHIFT;
          cnt <= s.in_amt;
          typ <= s.in_type;
          s.in_ready <= 1'b0;
          s.out_valid <= s.in_amt == '0;
          s.busy <= 1'b1;
        end
        SHIFT: begin
          cnt <= cnt - 1'b1;
          if (cnt == SW'(1)) begin
            state <= DONE;
            s.out_valid <= 1'b1;
          end
        end
        DONE: if (s.out_ready) begin
          state <= IDLE;
          s.in_ready <= 1'b1;
          s.out_valid <= 1'b0;
          s.busy <= 1'b0;
        end
        default: begin
          state <= IDLE;
          s.in_ready <= 1'b1;
          s.out_valid <= 1'b0;
          s.busy <= 1'b0;
        end
      endcase
`ifdef SHIFT_STICKY_EN
  logic sticky;
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) sticky <= 1'b0;
    else if (acc) sticky <= 1'b0;
    else if (sh) sticky <= sticky | s.out_data[0];
  assign s.out_sticky = sticky;
`else
  assign s.out_sticky = 1'b0;
`endif
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: scoreboard bench for shift_seq_ctrl (W=4, SW=3, RST_VAL=0)
module tb_shift_seq_ctrl;
  localparam int W = 4;
  localparam int SW = 3;
  typedef struct packed {logic [W-1:0] data; logic sticky;} exp_t;
  typedef struct packed {logic [W-1:0] d; logic [SW-1:0] amt; logic t; logic [W-1:0] r;} vec_t;
  logic clk = 1'b0;
  logic rst_b = 1'b0;
  int checks = 0;
  int passed = 0;
  exp_t sb[$];
  always #5 clk = ~clk;
  shift_seq_ctrl_if #(.W(W), .SW(SW)) bus();
  shift_seq_ctrl #(.W(W), .SW(SW), .RST_VAL(4'b0000)) dut (.clk(clk), .rst_b(rst_b), .s(bus));

  function automatic exp_t model(logic [W-1:0] d, int amt, logic t);
    logic s = 1'b0;
    for (int i = 0; i < amt; i++) begin
      s = s | d[0];
      d = {t ? d[W-1] : 1'b0, d[W-1:1]};
    end
`ifdef SHIFT_STICKY_EN
    return '{data: d, sticky: s};
`else
    return '{data: d, sticky: 1'b0};
`endif
  endfunction

  task automatic accept(input logic [W-1:0] d, input logic [SW-1:0] a, input logic t);
    int n = 0;
    bus.in_data = d;
    bus.in_amt = a;
    bus.in_type = t;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 50) $display("FAIL accept_timeout in_ready=%b required=1", bus.in_ready);
    else passed++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(output logic [W-1:0] d, output logic st, output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    d = bus.out_data;
    st = bus.out_sticky;
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    #12;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.out_data, bus.out_sticky} !== {3'b100, 4'b0000, 1'b0})
      $display("FAIL reset rdy/vld/busy/data/sticky=%b%b%b/%b/%b required=100/0000/0",
               bus.in_ready, bus.out_valid, bus.busy, bus.out_data, bus.out_sticky);
    else passed++;
    @(negedge clk) rst_b = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    vec_t v[7];
    exp_t e;
    logic [W-1:0] d;
    logic st;
    int lat;
    v[0] = {4'b1010, 3'd1, 1'b0, 4'b0101};
    v[1] = {4'b1010, 3'd2, 1'b1, 4'b1110};
    v[2] = {4'b1000, 3'd7, 1'b1, 4'b1111};
    v[3] = {4'b0110, 3'd5, 1'b0, 4'b0000};
    v[4] = {4'b1010, 3'd0, 1'b0, 4'b1010};
    v[5] = {4'b1011, 3'd2, 1'b0, 4'b0010};
    v[6] = {4'b1000, 3'd2, 1'b0, 4'b0010};
    for (int i = 0; i < 7; i++) begin
      accept(v[i].d, v[i].amt, v[i].t);
      sb.push_back('{data: v[i].r, sticky: model(v[i].d, int'(v[i].amt), v[i].t).sticky});
      collect(d, st, lat);
      e = sb.pop_front();
      checks++;
      if (d !== e.data) $display("FAIL vec%0d_data got=%b required=%b", i, d, e.data);
      else passed++;
      checks++;
      if (st !== e.sticky) $display("FAIL vec%0d_sticky got=%b required=%b", i, st, e.sticky);
      else passed++;
      checks++;
      if (v[i].amt == 0 ? lat > 1 : lat != int'(v[i].amt))
        $display("FAIL vec%0d_latency got=%0d required=%0d", i, lat, v[i].amt == 0 ? 1 : int'(v[i].amt));
      else passed++;
      checks++;
      if ({bus.in_ready, bus.busy} !== 2'b01)
        $display("FAIL vec%0d_done_status rdy/busy=%b%b required=01", i, bus.in_ready, bus.busy);
      else passed++;
      release_out();
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100)
        $display("FAIL vec%0d_idle rdy/vld/busy=%b%b%b required=100", i, bus.in_ready, bus.out_valid, bus.busy);
      else passed++;
    end
  endtask

  task automatic test_sticky();
    logic [W-1:0] d;
    logic st;
    int lat;
    logic want;
`ifdef SHIFT_STICKY_EN
    want = 1'b1;
`else
    want = 1'b0;
`endif
    accept(4'b1011, 3'd2, 1'b0);
    collect(d, st, lat);
    checks++;
    if ({d, st} !== {4'b0010, want}) $display("FAIL sticky_set data/sticky=%b/%b required=0010/%b", d, st, want);
    else passed++;
    release_out();
    accept(4'b1000, 3'd2, 1'b0);
    collect(d, st, lat);
    checks++;
    if ({d, st} !== {4'b0010, 1'b0}) $display("FAIL sticky_clear data/sticky=%b/%b required=0010/0", d, st);
    else passed++;
    release_out();
  endtask

  task automatic test_backpressure();
    exp_t e;
    logic [W-1:0] d;
    logic st;
    int lat;
    accept(4'b1001, 3'd3, 1'b1);
    sb.push_back(model(4'b1001, 3, 1'b1));
    collect(d, st, lat);
    e = sb.pop_front();
    checks++;
    if ({d, st} !== {e.data, e.sticky}) $display("FAIL bp_first got=%b/%b required=%b/%b", d, st, e.data, e.sticky);
    else passed++;
    bus.in_data = 4'b0101;
    bus.in_amt = 3'd1;
    bus.in_type = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.out_data, bus.out_sticky, bus.in_ready, bus.out_valid} !== {e.data, e.sticky, 2'b01})
        $display("FAIL bp_hold%0d data/sticky/rdy/vld=%b/%b/%b%b required=%b/%b/01",
                 i, bus.out_data, bus.out_sticky, bus.in_ready, bus.out_valid, e.data, e.sticky);
      else passed++;
    end
    release_out();
    checks++;
    if ({bus.in_ready, bus.busy, bus.out_data} !== {2'b10, e.data})
      $display("FAIL bp_no_same_edge rdy/busy/data=%b%b/%b required=10/%b", bus.in_ready, bus.busy, bus.out_data, e.data);
    else passed++;
    sb.push_back(model(4'b0101, 1, 1'b0));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if ({bus.in_ready, bus.busy} !== 2'b01)
      $display("FAIL bp_next_accept rdy/busy=%b%b required=01", bus.in_ready, bus.busy);
    else passed++;
    collect(d, st, lat);
    e = sb.pop_front();
    checks++;
    if ({d, st, lat} !== {e.data, e.sticky, 32'd1})
      $display("FAIL bp_second got=%b/%b lat=%0d required=%b/%b lat=1", d, st, lat, e.data, e.sticky);
    else passed++;
    release_out();
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    accept(4'b1111, 3'd6, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_b = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.out_data} !== {3'b100, 4'b0000})
      $display("FAIL reset_mid rdy/vld/busy/data=%b%b%b/%b required=100/0000",
               bus.in_ready, bus.out_valid, bus.busy, bus.out_data);
    else passed++;
    @(negedge clk) rst_b = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1 || bus.busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) $display("FAIL reset_abort active_cycles=%0d required=0", seen);
    else passed++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [W-1:0] d, rd;
    logic [SW-1:0] a;
    logic t, st;
    int lat;
    for (int i = 0; i < 10; i++) begin
      rd = W'($urandom_range(0, 15));
      a = SW'($urandom_range(0, 7));
      t = 1'($urandom_range(0, 1));
      accept(rd, a, t);
      sb.push_back(model(rd, int'(a), t));
      collect(d, st, lat);
      e = sb.pop_front();
      checks++;
      if ({d, st} !== {e.data, e.sticky})
        $display("FAIL b2b%0d in=%b amt=%0d type=%b got=%b/%b required=%b/%b", i, rd, a, t, d, st, e.data, e.sticky);
      else passed++;
      release_out();
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_amt = '0;
    bus.in_type = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_vectors();
    test_sticky();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_leftover size=%0d required=0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
